// File: rtl/dual_port_bram_ctrl_pkg.sv
// Shared types and constants for the dual-port BRAM controller slice.
// Optional feature macro used by the controller: RAM_CTRL_BYPASS_EN.
package ram_ctrl_pkg;

  // Controller sequencing states; BOOT is the reset state.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_e;

  // Word written to every location by the INIT and FLUSH sweeps.
  localparam int unsigned SWEEP_FILL = 0;

endpackage

// File: rtl/dual_port_bram_ctrl_if.sv
// Read/write requester handshake bundle for dual_port_bram_ctrl.
// master: requester side (cache FSM); slave: controller side.
interface dual_port_bram_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AW         = 7
);
  logic                  rd_req;
  logic [AW-1:0]         rd_addr;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ready, rd_valid, rd_data, wr_ready
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ready, rd_valid, rd_data, wr_ready
  );
endinterface

// File: rtl/dual_port_bram_ctrl_sweep_cnt.sv
// Address counter for the INIT/FLUSH clearing sweeps. Rests at 0 while
// disabled so each sweep starts from address 0; stops after DEPTH-1.
module ram_sweep_cnt #(
  parameter  int unsigned DEPTH = 128,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [AW-1:0] cnt_o,
  output logic          start_o,
  output logic          last_o
);

  logic [AW-1:0] cnt_q, cnt_d;

  assign cnt_o   = cnt_q;
  assign start_o = (cnt_q == '0);
  assign last_o  = (cnt_q == AW'(DEPTH - 1));

  // Next count: advance while sweeping, otherwise park at zero.
  always_comb begin
    cnt_d = '0;
    if (en_i && !last_o) cnt_d = cnt_q + AW'(1);
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dual_port_bram_ctrl.sv
// Sequencer/port controller for one latency-1 dual_port_bram used as a cache
// store: clears the array after reset and on flush, serves one reader on
// port B and one writer on port A, and resolves same-address collisions.
// Macro RAM_CTRL_BYPASS_EN: defined -> same-address read+write both accepted,
// read returns the new word via a forward register; undefined -> the read
// stalls for that cycle.
module dual_port_bram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 128,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_port_bram_ctrl_if.slave  bus,
  input  logic                  flush_req,
  output logic                  busy,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [AW-1:0]         ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [AW-1:0]         ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  ctrl_state_e   state_q;
  logic          busy_q;
  logic          rd_valid_q;
  logic [AW-1:0] sweep_cnt;
  logic          sweep_start, sweep_last;
  logic          in_run, in_sweep;
  logic          addr_match, rd_ready, rd_acc, wr_acc;

  assign in_run     = (state_q == RUN);
  assign in_sweep   = (state_q == INIT) || (state_q == FLUSH);
  assign addr_match = (bus.rd_addr == bus.wr_addr);

  ram_sweep_cnt #(.DEPTH(DEPTH)) u_sweep_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (in_sweep),
    .cnt_o   (sweep_cnt),
    .start_o (sweep_start),
    .last_o  (sweep_last)
  );

`ifdef RAM_CTRL_BYPASS_EN
  assign rd_ready = in_run;
`else
  assign rd_ready = in_run && !(bus.wr_req && addr_match);
`endif

  assign rd_acc       = bus.rd_req && rd_ready;
  assign wr_acc       = bus.wr_req && in_run;
  assign bus.rd_ready = rd_ready;
  assign bus.wr_ready = in_run;
  assign bus.rd_valid = rd_valid_q;
  assign busy         = busy_q;

  // Sequencer: BOOT -> INIT sweep -> RUN, RUN -> FLUSH sweep on request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= INIT;
          busy_q  <= 1'b1;
        end
        INIT, FLUSH: begin
          if (sweep_last) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (flush_req) begin
            state_q <= FLUSH;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // A sweep may only be entered while the counter is parked at address 0.
  always_ff @(posedge clk) begin
    if (rst && ((state_q == BOOT) || (in_run && flush_req)))
      assert (sweep_start);
  end

  // Port A: sweep clears take the port; otherwise the accepted write.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    if (in_sweep) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = sweep_cnt;
      ram_dina  = DATA_WIDTH'(SWEEP_FILL);
    end else if (wr_acc) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = bus.wr_addr;
      ram_dina  = bus.wr_data;
    end
  end

  // Port B: read-only, strobed only for an accepted read.
  always_comb begin
    ram_enb   = rd_acc;
    ram_addrb = rd_acc ? bus.rd_addr : '0;
  end

  // Read data is valid exactly one cycle after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_valid_q <= 1'b0;
    else      rd_valid_q <= rd_acc;
  end

`ifdef RAM_CTRL_BYPASS_EN
  logic                  fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  // The RAM returns stale data on a same-address collision, so capture the
  // written word and substitute it on the following rd_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q <= rd_acc && wr_acc && addr_match;
      if (wr_acc) fwd_data_q <= bus.wr_data;
    end
  end

  assign bus.rd_data = fwd_hit_q ? fwd_data_q : ram_doutb;
`else
  assign bus.rd_data = ram_doutb;
`endif

endmodule

// File: tb/tb_dual_port_bram_ctrl.sv
// Scoreboard bench for dual_port_bram_ctrl (DEPTH=8). Build with or without
// RAM_CTRL_BYPASS_EN; the reference model follows the same macro.
module tb_dual_port_bram_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_req;
  logic          busy, ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;

  dual_port_bram_ctrl_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  dual_port_bram_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush_req (flush_req),
    .busy      (busy),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  always #5 clk = ~clk;

  // Stand-in for the dual_port_bram primitive: latency 1, read-first.
  logic [DW-1:0] ram_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= ram_mem[ram_addrb];
  end

  int            vectors    = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned   busy_cnt;   // cycles of busy remaining, including the current one

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic b, input logic rr, input logic wr,
                                       input logic ea, input logic wa, input logic [AW-1:0] aa,
                                       input logic [DW-1:0] da, input logic eb, input logic [AW-1:0] ab);
    return 64'({b, rr, wr, ea, wa, aa, da, eb, ab});
  endfunction

  function automatic logic [63:0] ctl_act();
    return pack(busy, bus.rd_ready, bus.wr_ready, ram_ena, ram_wea, ram_addra, ram_dina,
                ram_enb, ram_addrb);
  endfunction

  task automatic idle_inputs();
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; flush_req = 1'b0;
  endtask

  task automatic restart_model();
    busy_cnt = DEPTH + 1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic check_reset_vals();
    check("rst_ctl", ctl_act(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0));
    check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
  endtask

  // One clock cycle; entered and left at negedge+1. rst_mid pulls reset low
  // after the cycle's checks, before the next active edge.
  task automatic cycle(input logic rq, input logic [AW-1:0] ra, input logic wq,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic fl, input logic rst_mid);
    logic          run, e_rr, e_ena, rd_acc, wr_acc;
    logic [AW-1:0] e_addra;
    logic [DW-1:0] e_dina;
    bus.rd_req = rq; bus.rd_addr = ra; bus.wr_req = wq;
    bus.wr_addr = wa; bus.wr_data = wd; flush_req = fl;
    #1;
    run  = (busy_cnt == 0);
    e_rr = run;
`ifndef RAM_CTRL_BYPASS_EN
    if (wq && wa == ra) e_rr = 1'b0;
`endif
    rd_acc  = rq && e_rr;
    wr_acc  = wq && run;
    e_ena   = 1'b0;
    e_addra = '0;
    e_dina  = '0;
    if (!run && busy_cnt <= DEPTH) begin
      e_ena   = 1'b1;
      e_addra = AW'(DEPTH - busy_cnt);
    end else if (wr_acc) begin
      e_ena   = 1'b1;
      e_addra = wa;
      e_dina  = wd;
    end
    check("ctl", ctl_act(), pack(!run, e_rr, run, e_ena, e_ena, e_addra, e_dina,
                                 rd_acc, rd_acc ? ra : '0));
    if (rd_acc) exp_q.push_back((wr_acc && wa == ra) ? wd : ref_mem[ra]);
    if (wr_acc) ref_mem[wa] = wd;
    if (rst_mid) begin
      #1 rst = 1'b0;
      #1 check_reset_vals();
      exp_q.delete();
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      restart_model();
    end else begin
      @(posedge clk);
      if (busy_cnt > 0) busy_cnt--;
      else if (fl) begin
        busy_cnt = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: pop one expectation per rd_valid; nothing may appear in reset.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rd_valid_in_reset", 64'(bus.rd_valid), 64'(0));
      end else if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_valid_unexpected: got data %h expected no rd_valid at %0t",
                   bus.rd_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 64'(bus.rd_data), 64'(e));
        end
      end
    end
  end

  initial begin
    idle_inputs();
    restart_model();
    repeat (2) @(negedge clk);
    #1 check_reset_vals();
    rst = 1'b1;
    restart_model();

    // BOOT + INIT sweep.
    idle(DEPTH + 1);

    // Write then read the next cycle.
    cycle(1'b0, 3'd0, 1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle(1'b1, 3'd5, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    idle(1);

    // Same-cycle read/write to one address, then a re-read.
    cycle(1'b1, 3'd3, 1'b1, 3'd3, 32'h0000_1234, 1'b0, 1'b0);
    cycle(1'b1, 3'd3, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    idle(1);

    // Back-to-back reads with concurrent writes elsewhere.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, AW'(i), 1'b1, AW'(i + 4), $urandom, 1'b0, 1'b0);
    idle(2);

    // Flush after writing addr 2; flush requests during the sweep are ignored.
    cycle(1'b0, '0, 1'b1, 3'd2, 32'h0000_00A5, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b0, '0, '0, 1'b1, 1'b0);
    repeat (DEPTH) cycle(1'b1, AW'($urandom_range(0, DEPTH - 1)), 1'b1,
                         AW'($urandom_range(0, DEPTH - 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b1, 3'd2, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1);

    // Reset at flush counter 4.
    cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(4);
    cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // Reset right after a read is accepted: its rd_valid must never appear.
    cycle(1'b0, '0, 1'b1, 3'd1, 32'h5555_AAAA, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // Randomized traffic with occasional flushes.
    repeat (1500)
      cycle(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, DEPTH - 1)),
            1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, DEPTH - 1)),
            $urandom, 1'($urandom_range(0, 59) == 0), 1'b0);

    idle(3);
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
